// File: rtl/step_pulse_gen.sv
// rtl/step_pulse_gen.sv - debounced single-step clock generator; optional auto-repeat under STEP_AUTOREPEAT_EN
module step_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int PULSE_CYCLES    = 16,
  parameter int GAP_CYCLES      = 16,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 step_btn_n,
  output logic                 step_clk,
  output logic [CNT_WIDTH-1:0] step_count,
  output logic                 busy,
  output logic                 btn_level
);

  localparam int DB_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TMAX  = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TMR_W = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  logic             sync_1;
  logic             sync_2;
  logic             press_sync;
  logic [DB_W-1:0]  db_cnt;
  logic             level_q;
  logic             press_evt;
  logic             step_evt;
  state_t           state;
  logic [TMR_W-1:0] tmr;
  logic             pending;

  // Two-flop synchroniser; idles at 1 so reset looks like a released button
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1 <= 1'b1;
      sync_2 <= 1'b1;
    end else begin
      sync_1 <= step_btn_n;
      sync_2 <= sync_1;
    end
  end

  assign press_sync = ~sync_2;

  // Debounce: accept a new level only after it differs from btn_level for DEBOUNCE_CYCLES edges in a row
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_cnt    <= '0;
      btn_level <= 1'b0;
    end else if (press_sync == btn_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt    <= '0;
      btn_level <= ~btn_level;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  // Delayed copy of btn_level for rising-edge detection (presses only, releases ignored)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= btn_level;
    end
  end

  assign press_evt = btn_level & ~level_q;

`ifdef STEP_AUTOREPEAT_EN
  // First synthetic press lands 2^20 + 2^18 cycles into a hold, then one every 2^18 cycles
  localparam logic [20:0] REP_LAST   = 21'((1 << 20) + (1 << 18) - 1);
  localparam logic [20:0] REP_RELOAD = 21'(1 << 20);

  logic [20:0] rep_cnt;
  logic        rep_evt;

  // Hold timer: runs while the debounced button is held, cleared on release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rep_cnt <= '0;
      rep_evt <= 1'b0;
    end else if (!btn_level) begin
      rep_cnt <= '0;
      rep_evt <= 1'b0;
    end else if (rep_cnt == REP_LAST) begin
      rep_cnt <= REP_RELOAD;
      rep_evt <= 1'b1;
    end else begin
      rep_cnt <= rep_cnt + 21'd1;
      rep_evt <= 1'b0;
    end
  end

  assign step_evt = press_evt | rep_evt;
`else
  assign step_evt = press_evt;
`endif

  // Pulse sequencer: IDLE -> PULSE -> GAP, with a single pending press carried across a busy period
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      tmr        <= '0;
      pending    <= 1'b0;
      step_clk   <= 1'b0;
      busy       <= 1'b0;
      step_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (step_evt) begin
            state      <= PULSE;
            step_clk   <= 1'b1;
            busy       <= 1'b1;
            step_count <= step_count + CNT_WIDTH'(1);
            tmr        <= PULSE_LOAD;
          end
        end
        PULSE: begin
          if (step_evt) begin
            pending <= 1'b1;
          end
          if (tmr == '0) begin
            state    <= GAP;
            step_clk <= 1'b0;
            tmr      <= GAP_LOAD;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        GAP: begin
          if (tmr == '0) begin
            // A press arriving on this very edge is treated the same as one already pending
            if (pending || step_evt) begin
              state      <= PULSE;
              step_clk   <= 1'b1;
              step_count <= step_count + CNT_WIDTH'(1);
              tmr        <= PULSE_LOAD;
              pending    <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            tmr <= tmr - TMR_W'(1);
            if (step_evt) begin
              pending <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          step_clk <= 1'b0;
          busy     <= 1'b0;
          pending  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_step_pulse_gen.sv
// tb/tb_step_pulse_gen.sv - bench for step_pulse_gen: reference model, vector table and directed sequences
module tb_step_pulse_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        btn_a, btn_b;
  logic        sclk_a, busy_a, lvl_a;
  logic [15:0] cnt_a;
  logic        sclk_b, busy_b, lvl_b;
  logic [3:0]  cnt_b;

  step_pulse_gen #(.DEBOUNCE_CYCLES(8), .PULSE_CYCLES(4), .GAP_CYCLES(3), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .reset(reset), .step_btn_n(btn_a),
    .step_clk(sclk_a), .step_count(cnt_a), .busy(busy_a), .btn_level(lvl_a)
  );

  step_pulse_gen #(.DEBOUNCE_CYCLES(2), .PULSE_CYCLES(4), .GAP_CYCLES(3), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .reset(reset), .step_btn_n(btn_b),
    .step_clk(sclk_b), .step_count(cnt_b), .busy(busy_b), .btn_level(lvl_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: instance 0 is dut_a, instance 1 is dut_b. Time is the edge index k.
  int k = 0;
  bit q0 [2];
  bit q1 [2];
  bit m_lvl [2];
  bit m_ev [2];
  int run_start [2];
  int free_at [2];
  int last_start [2];
  int pend_at [2];
  int m_cnt [2];

  function automatic int p_deb(int i);  return (i == 0) ? 8 : 2;  endfunction
  function automatic int p_cw(int i);   return (i == 0) ? 16 : 4; endfunction
  localparam int P_PULSE = 4;
  localparam int P_GAP   = 3;

  function automatic void model_reset(int i);
    q0[i] = 1'b1; q1[i] = 1'b1;
    m_lvl[i] = 1'b0; m_ev[i] = 1'b0;
    run_start[i] = -1; free_at[i] = -1; last_start[i] = -1000; pend_at[i] = -1;
    m_cnt[i] = 0;
  endfunction

  function automatic void start_pulse(int i);
    last_start[i] = k;
    free_at[i] = k + P_PULSE + P_GAP;
    m_cnt[i] = (m_cnt[i] + 1) % (1 << p_cw(i));
  endfunction

  function automatic void model_edge(int i, bit b);
    bit x, evt, started;
    x = !q0[i];
    q0[i] = q1[i];
    q1[i] = b;
    evt = m_ev[i];
    m_ev[i] = 1'b0;
    if (x == m_lvl[i]) begin
      run_start[i] = -1;
    end else begin
      if (run_start[i] < 0) run_start[i] = k;
      if (k - run_start[i] + 1 >= p_deb(i)) begin
        m_lvl[i] = !m_lvl[i];
        run_start[i] = -1;
        m_ev[i] = m_lvl[i];
      end
    end
    started = 1'b0;
    if (pend_at[i] == k) begin
      start_pulse(i);
      pend_at[i] = -1;
      started = 1'b1;
    end
    if (evt && !started) begin
      if (k >= free_at[i]) start_pulse(i);
      else if (pend_at[i] < 0) pend_at[i] = free_at[i];
    end
  endfunction

  function automatic bit m_sclk(int i);
    return (k >= last_start[i]) && (k < last_start[i] + P_PULSE);
  endfunction

  function automatic bit m_busy(int i);
    return k < free_at[i];
  endfunction

  function automatic void check(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, k);
    end
  endfunction

  function automatic void compare_all();
    check("a.step_clk", sclk_a, m_sclk(0));
    check("a.busy", busy_a, m_busy(0));
    check("a.btn_level", lvl_a, m_lvl[0]);
    check("a.step_count", cnt_a, m_cnt[0]);
    check("b.step_clk", sclk_b, m_sclk(1));
    check("b.busy", busy_b, m_busy(1));
    check("b.btn_level", lvl_b, m_lvl[1]);
    check("b.step_count", cnt_b, m_cnt[1]);
  endfunction

  int  pulses_a = 0, hi_a = 0, busyc_a = 0, streak_a = 0;
  int  pulses_b = 0, hi_b = 0, busyc_b = 0;
  bit  prev_a = 1'b0, prev_b = 1'b0;

  // One clock: drive at negedge, advance model at posedge, compare at the following negedge
  task automatic tick(input bit ba, input bit bb);
    btn_a = ba;
    btn_b = bb;
    @(posedge clk);
    if (reset) begin
      k++;
      model_edge(0, ba);
      model_edge(1, bb);
    end else begin
      model_reset(0);
      model_reset(1);
    end
    @(negedge clk);
    compare_all();
    if (sclk_a && !prev_a) pulses_a++;
    if (sclk_b && !prev_b) pulses_b++;
    if (sclk_a) hi_a++;
    if (sclk_b) hi_b++;
    if (busy_a) busyc_a++;
    if (busy_b) busyc_b++;
    streak_a = sclk_a ? streak_a + 1 : 0;
    prev_a = sclk_a;
    prev_b = sclk_b;
  endtask

  typedef struct {
    int low;
    int high;
    int exp_pulses;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int lvl_at, sclk_at, p0, h0, b0, c0, n;
    bit any_lvl;
    int rem_a, rem_b;
    bit ra, rb;

    vecs[0] = '{low: 3,   high: 30, exp_pulses: 0};
    vecs[1] = '{low: 7,   high: 30, exp_pulses: 0};
    vecs[2] = '{low: 8,   high: 30, exp_pulses: 1};
    vecs[3] = '{low: 9,   high: 30, exp_pulses: 1};
    vecs[4] = '{low: 100, high: 30, exp_pulses: 1};
    vecs[5] = '{low: 1,   high: 30, exp_pulses: 0};

    // Reset with button A held down
    reset = 1'b0;
    btn_a = 1'b0;
    btn_b = 1'b1;
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    for (int t = 0; t < 3; t++) tick(1'b0, 1'b1);
    check("rst.step_clk", sclk_a, 0);
    check("rst.step_count", cnt_a, 0);
    check("rst.busy", busy_a, 0);
    check("rst.btn_level", lvl_a, 0);

    // Release reset with the button still held: one pulse after 2+8 cycles
    reset = 1'b1;
    lvl_at = -1;
    sclk_at = -1;
    p0 = pulses_a; h0 = hi_a; b0 = busyc_a;
    for (int t = 1; t <= 40; t++) begin
      tick(1'b0, 1'b1);
      if (lvl_a && lvl_at < 0) lvl_at = t;
      if (sclk_a && sclk_at < 0) sclk_at = t;
    end
    check("held.level_latency", lvl_at, 10);
    check("held.pulse_start", sclk_at, 11);
    check("held.pulses", pulses_a - p0, 1);
    check("held.high_cycles", hi_a - h0, 4);
    check("held.busy_cycles", busyc_a - b0, 7);
    check("held.step_count", cnt_a, 1);
    for (int t = 0; t < 30; t++) tick(1'b1, 1'b1);

    // Bounce: 3-cycle toggles never survive an 8-cycle debounce
    p0 = pulses_a;
    any_lvl = 1'b0;
    for (int t = 0; t < 50; t++) begin
      tick((t < 30) ? (((t / 3) % 2) != 0) : 1'b1, 1'b1);
      if (lvl_a) any_lvl = 1'b1;
    end
    check("bounce.btn_level_seen", any_lvl, 0);
    check("bounce.pulses", pulses_a - p0, 0);
    check("bounce.step_count", cnt_a, 1);

    // Vector table: press length vs. number of pulses on dut_a
    for (int v = 0; v < 6; v++) begin
      p0 = pulses_a; h0 = hi_a; b0 = busyc_a; c0 = cnt_a;
      for (int t = 0; t < vecs[v].low; t++) tick(1'b0, 1'b1);
      for (int t = 0; t < vecs[v].high; t++) tick(1'b1, 1'b1);
      check($sformatf("vec%0d.pulses", v), pulses_a - p0, vecs[v].exp_pulses);
      check($sformatf("vec%0d.high_cycles", v), hi_a - h0, 4 * vecs[v].exp_pulses);
      check($sformatf("vec%0d.busy_cycles", v), busyc_a - b0, 7 * vecs[v].exp_pulses);
      check($sformatf("vec%0d.count_delta", v), (cnt_a - c0) & 16'hFFFF, vecs[v].exp_pulses);
      check($sformatf("vec%0d.btn_level", v), lvl_a, 0);
    end

    // Pending on dut_b (debounce 2): presses at ticks 1,5,9,13 -> events at 5,9,13,17
    p0 = pulses_b; h0 = hi_b; b0 = busyc_b;
    for (int t = 1; t <= 36; t++) begin
      tick(1'b1, (t <= 16) ? (((t - 1) % 4) >= 2) : 1'b1);
      if (t == 11) begin
        check("pend.t11_busy", busy_b, 1);
        check("pend.t11_step_clk", sclk_b, 0);
      end
      if (t == 12) begin
        check("pend.t12_step_clk", sclk_b, 1);
        check("pend.t12_busy", busy_b, 1);
      end
    end
    check("pend.pulses", pulses_b - p0, 3);
    check("pend.busy_cycles", busyc_b - b0, 21);
    check("pend.high_cycles", hi_b - h0, 12);
    check("pend.step_count", cnt_b, 3);

    // Wrap of the 4-bit counter on dut_b
    for (int p = 0; p < 12; p++) begin
      for (int t = 0; t < 2; t++) tick(1'b1, 1'b0);
      for (int t = 0; t < 10; t++) tick(1'b1, 1'b1);
    end
    check("wrap.at_max", cnt_b, 15);
    for (int t = 0; t < 2; t++) tick(1'b1, 1'b0);
    for (int t = 0; t < 10; t++) tick(1'b1, 1'b1);
    check("wrap.to_zero", cnt_b, 0);

    // Reset asserted during the second cycle of a pulse on dut_a
    n = 0;
    while (streak_a < 2 && n < 40) begin
      tick(1'b0, 1'b1);
      n++;
    end
    check("rstmid.reached_pulse", streak_a, 2);
    reset = 1'b0;
    btn_a = 1'b1;
    #1;
    model_reset(0);
    model_reset(1);
    check("rstmid.step_clk_async", sclk_a, 0);
    check("rstmid.busy_async", busy_a, 0);
    check("rstmid.count_async", cnt_a, 0);
    @(negedge clk);
    for (int t = 0; t < 2; t++) tick(1'b1, 1'b1);
    reset = 1'b1;
    p0 = pulses_a;
    for (int t = 0; t < 40; t++) tick(1'b1, 1'b1);
    check("rstmid.no_resume", pulses_a - p0, 0);
    check("rstmid.step_count", cnt_a, 0);
    check("rstmid.busy", busy_a, 0);

    // Random run-length button activity on both instances against the model
    rem_a = 0; rem_b = 0; ra = 1'b1; rb = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      if (rem_a == 0) begin
        ra = ~ra;
        rem_a = $urandom_range(1, 14);
      end
      if (rem_b == 0) begin
        rb = ~rb;
        rem_b = $urandom_range(1, 6);
      end
      tick(ra, rb);
      rem_a--;
      rem_b--;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/step_pulse_gen.md
Name: step_pulse_gen

Overview:
- Upstream source of the CPU's single-step clock.
- Synchronises and debounces a raw, active-low step pushbutton on the board clock `clk`.
- Each accepted press produces exactly one clean high pulse, `step_clk`, of fixed width. `step_clk` drives every sequential block of the CPU.
- Also exports a step counter and a busy flag for LED/debug use.

Parameters:
- DEBOUNCE_CYCLES, 250000, clk cycles the synchronised button level must stay stable before a level change is accepted (min 2).
- PULSE_CYCLES, 16, width of each step_clk high phase in clk cycles (min 1).
- GAP_CYCLES, 16, minimum step_clk low time after each pulse before another pulse may start (min 1).
- CNT_WIDTH, 16, width of step_count.

Ports:
- clk  input  1  board clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- step_btn_n  input  1  raw step pushbutton, active-low, asynchronous to clk.
- step_clk  output  1  registered one-shot clock to the CPU.
- step_count  output  CNT_WIDTH  number of step_clk pulses issued since reset; wraps modulo 2^CNT_WIDTH.
- busy  output  1  high while a pulse or its gap is in progress.
- btn_level  output  1  debounced button state, 1 = pressed.

Behaviour:
- Reset (reset=0, asynchronous): step_clk=0, step_count=0, busy=0, btn_level=0.
  - Synchroniser stages reset to 1 (released); debounce counter cleared; FSM to IDLE.
  - Reset mid-pulse truncates the pulse immediately. No partial count is recorded.
- Synchroniser: 2 flip-flops on step_btn_n. Internal press = ~synced value.
- Debounce:
  - Counter reloads to 0 whenever the synced press level equals btn_level.
  - Otherwise it counts up by 1 per clk.
  - When the counter reaches DEBOUNCE_CYCLES-1, btn_level toggles on that edge and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES are ignored.
  - Press-to-btn_level latency: 2 + DEBOUNCE_CYCLES clk cycles.
- Press event: one-cycle internal strobe on each 0->1 transition of btn_level. Releases produce no event.
- FSM states: IDLE, PULSE, GAP.
  - IDLE: step_clk=0, busy=0. On a press event -> PULSE: on the same edge step_clk<=1, busy<=1, step_count<=step_count+1, and the width counter is loaded.
  - PULSE: step_clk=1 for exactly PULSE_CYCLES cycles, then -> GAP with step_clk<=0.
  - GAP: step_clk=0, busy=1 for exactly GAP_CYCLES cycles, then -> IDLE with busy<=0.
- Press event while in PULSE or GAP: latched in a 1-deep pending flag.
  - On leaving GAP with pending=1, go directly to PULSE (a new pulse starts) instead of IDLE, and clear pending.
  - Further presses while pending=1 are dropped (saturates at one).
- step_count increments only at the start of a pulse. It wraps from 2^CNT_WIDTH-1 to 0.
- step_clk is driven straight from a flip-flop, never from combinational logic, so it is glitch-free.

Optional Feature:
- Macro STEP_AUTOREPEAT_EN.
- When defined:
  - While btn_level stays 1 for more than 2^20 clk cycles after the initial press event, the block generates a synthetic press event every 2^18 clk cycles until release.
  - Each synthetic event follows the normal pending/FSM rules.
  - The repeat timer clears on release and on reset.
- When undefined: the repeat logic is absent. One physical press produces exactly one pulse regardless of hold time.

Test Plan (DEBOUNCE_CYCLES=8, PULSE_CYCLES=4, GAP_CYCLES=3 unless noted):
- Reset with step_btn_n held low, then release reset with the button still held -> step_clk=0, step_count=0 during reset. After 2+8 cycles btn_level=1 and exactly one 4-cycle step_clk pulse occurs; step_count=1.
- Bounce: toggle step_btn_n low/high every 3 cycles for 30 cycles, then hold high -> btn_level stays 0, no step_clk pulse, step_count=0.
- Clean press held 100 cycles, then release -> exactly one pulse, high for 4 cycles and followed by 3 low cycles with busy=1, then busy=0; step_count=1.
- Second debounced press arriving during GAP, with DEBOUNCE_CYCLES=2 -> pending set. The next pulse starts on the cycle GAP ends (no IDLE cycle); step_count=2. A third press during that pulse yields one more pulse; a fourth during the same window is dropped.
- Preload step_count to 0xFFFF via forced presses (CNT_WIDTH=16), then one more press -> step_count=0x0000.
- Assert reset during the 2nd cycle of PULSE -> step_clk=0 asynchronously; after release FSM=IDLE, step_count=0, no resumed pulse.
